// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master sram arbiter: FSM encodings, master indices, byte strobes.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_DATA  = 1'b1;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the last_grant history register lives in the caller.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] elig;

  always_comb begin
    elig        = req & ~mask;
    grant_valid = |elig;
    grant_idx   = M_FETCH;
    case (elig)
      2'b01:   grant_idx = M_FETCH;
      2'b10:   grant_idx = M_DATA;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = M_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (m0) and load/store (m1) masters onto one sram port with a
// setup/access handshake and a watchdog on a stalled slave.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rts,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_wr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_strb,
  output logic            m0_gnt,
  output logic            m0_done,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_wr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_strb,
  output logic            m1_gnt,
  output logic            m1_done,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  output logic            apb_sel,
  output logic            apb_en,
  output logic            apb_wr,
  output logic [AW-1:0]   apb_addr,
  output logic [DW-1:0]   apb_wdata,
  output logic [DW/8-1:0] apb_strb,
  input  logic [DW-1:0]   apb_rdata,
  input  logic            apb_ready
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          en_q, en_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] strb_q, strb_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic grant_valid;
  logic grant_idx;
  logic timeout_hit_c;

  // A master that just saw done sits out one IDLE cycle so it can drop req cleanly.
  rr_arb2 u_rr (
    .req         ({m1_req, m0_req}),
    .mask        (done_q),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // cnt_q counts completed ACCESS cycles, so the TIMEOUT-th cycle is the last one.
  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    en_d         = en_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = SETUP;
          last_grant_d = grant_idx;
          cnt_d        = '0;
          sel_d        = 1'b1;
          en_d         = 1'b0;
          gnt_d[grant_idx] = 1'b1;
          if (grant_idx == M_DATA) begin
            wr_d    = m1_wr;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            strb_d  = m1_strb;
          end else begin
            wr_d    = m0_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            strb_d  = m0_strb;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        en_d    = 1'b1;
      end
      ACCESS: begin
        if (apb_ready) begin
          state_d = IDLE;
          sel_d   = 1'b0;
          en_d    = 1'b0;
          done_d[last_grant_q] = 1'b1;
          if (!wr_q) begin
            if (last_grant_q == M_DATA) rdata1_d = apb_rdata;
            else                        rdata0_d = apb_rdata;
          end
        end else if (timeout_hit_c) begin
          state_d = IDLE;
          sel_d   = 1'b0;
          en_d    = 1'b0;
          done_d[last_grant_q] = 1'b1;
          err_d[last_grant_q]  = 1'b1;
          if (last_grant_q == M_DATA) rdata1_d = '0;
          else                        rdata0_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rts) begin
      state_q      <= IDLE;
      last_grant_q <= M_DATA;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      en_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign apb_sel   = sel_q;
  assign apb_en    = en_q;
  assign apb_wr    = wr_q;
  assign apb_addr  = addr_q;
  assign apb_wdata = wdata_q;
  assign apb_strb  = strb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transfers, a bus-slave model and a done/gnt monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rts;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_strb, m1_strb;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        apb_sel, apb_en, apb_wr, apb_ready;
  logic [31:0] apb_addr, apb_wdata, apb_rdata;
  logic [3:0]  apb_strb;

  int total = 0;
  int bad   = 0;

  int          s_wait  = 0;
  bit          s_never = 1'b0;
  int          s_acc   = 0;

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rts(rts),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_wdata(m0_wdata), .m0_strb(m0_strb),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wdata(m1_wdata), .m1_strb(m1_strb),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .apb_sel(apb_sel), .apb_en(apb_en), .apb_wr(apb_wr), .apb_addr(apb_addr),
    .apb_wdata(apb_wdata), .apb_strb(apb_strb), .apb_rdata(apb_rdata), .apb_ready(apb_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave: ready after s_wait wait states of ACCESS, or never when s_never is set.
  always @(negedge clk) begin
    if (apb_sel && apb_en) begin
      apb_ready = (!s_never && s_acc == s_wait);
      s_acc++;
    end else begin
      apb_ready = 1'b0;
      s_acc = 0;
    end
  end

  // Monitor: every gnt, bus cycle and done is matched against the head of the queue.
  always @(negedge clk) begin
    if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
      if (q.size() == 0) chk("gnt_unexpected", 160'({m1_gnt, m0_gnt}), 160'(0));
      else chk("gnt_master", 160'({m1_gnt, m0_gnt}), 160'(q[0].m ? 2'b10 : 2'b01));
    end
    if (apb_sel === 1'b1) begin
      if (q.size() == 0) chk("sel_unexpected", 160'(apb_sel), 160'(0));
      else chk("bus_payload", 160'({apb_wr, apb_addr, apb_wdata, apb_strb}),
               160'({q[0].wr, q[0].addr, q[0].wdata, q[0].strb}));
    end
    if (m0_done === 1'b1 || m1_done === 1'b1) begin
      if (q.size() == 0) chk("done_unexpected", 160'({m1_done, m0_done}), 160'(0));
      else begin
        mon_e = q.pop_front();
        chk("done_master", 160'({m1_done, m0_done}), 160'(mon_e.m ? 2'b10 : 2'b01));
        chk("done_err", 160'({m1_err, m0_err}),
            160'(mon_e.err ? (mon_e.m ? 2'b10 : 2'b01) : 2'b00));
        chk("done_rdata", 160'(mon_e.m ? m1_rdata : m0_rdata), 160'(mon_e.rdata));
      end
    end
  end

  task automatic expect_txn(input logic m, input logic [31:0] a, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st,
                            input logic err, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.addr = a; e.wr = wr; e.wdata = wd; e.strb = st; e.err = err; e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic issue(input logic m, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st);
    if (m == M_DATA) begin
      m1_addr = a; m1_wr = wr; m1_wdata = wd; m1_strb = st; m1_req = 1'b1;
    end else begin
      m0_addr = a; m0_wr = wr; m0_wdata = wd; m0_strb = st; m0_req = 1'b1;
    end
  endtask

  // Run until each master has seen its quota of done, dropping req on the last one.
  task automatic run_until(input int n0, input int n1, output int en_cnt);
    int c0 = 0;
    int c1 = 0;
    en_cnt = 0;
    for (int i = 0; i < 400 && (c0 < n0 || c1 < n1); i++) begin
      @(negedge clk);
      if (apb_en) en_cnt++;
      if (m0_done) begin c0++; if (c0 >= n0) m0_req = 1'b0; end
      if (m1_done) begin c1++; if (c1 >= n1) m1_req = 1'b0; end
    end
    if (c0 < n0 || c1 < n1) chk("run_until_timeout", 160'({c1[7:0], c0[7:0]}), 160'({n1[7:0], n0[7:0]}));
  endtask

  task automatic do_reset();
    rts = 1'b1;
    repeat (2) @(negedge clk);
    rts = 1'b0;
  endtask

  int en;
  int k;

  initial begin
    rts = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_wr = 1'b0; m0_wdata = '0; m0_strb = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wr = 1'b0; m1_wdata = '0; m1_strb = '0;
    apb_rdata = '0; apb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 160'({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, apb_sel, apb_en, apb_wr}), 160'(0));
    chk("reset_data", 160'({m0_rdata, m1_rdata, apb_addr, apb_wdata, apb_strb}), 160'(0));
    rts = 1'b0;
    @(negedge clk);

    // Single read, ready in the first ACCESS cycle
    s_wait = 0; s_never = 1'b0; apb_rdata = 32'hDEAD_BEEF;
    expect_txn(M_FETCH, 32'h10, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'hDEAD_BEEF);
    issue(M_FETCH, 32'h10, 1'b0, 32'h0, STRB_WORD);
    @(negedge clk);
    chk("t1_setup", 160'({m0_gnt, m1_gnt, apb_sel, apb_en}), 160'(4'b1010));
    @(negedge clk);
    chk("t1_access", 160'({m0_gnt, apb_sel, apb_en, m0_done}), 160'(4'b0110));
    @(negedge clk);
    chk("t1_done", 160'({m0_done, m0_err, apb_sel, apb_en}), 160'(4'b1000));
    m0_req = 1'b0;
    repeat (2) @(negedge clk);

    // Conflict right after reset: m0 first, then strict alternation while both held
    do_reset();
    apb_rdata = 32'hA5A5_0001;
    expect_txn(M_FETCH, 32'h100, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'hA5A5_0001);
    expect_txn(M_DATA,  32'h200, 1'b0, 32'h0, STRB_HALF, 1'b0, 32'hA5A5_0001);
    expect_txn(M_FETCH, 32'h100, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'hA5A5_0001);
    expect_txn(M_DATA,  32'h200, 1'b0, 32'h0, STRB_HALF, 1'b0, 32'hA5A5_0001);
    issue(M_FETCH, 32'h100, 1'b0, 32'h0, STRB_WORD);
    issue(M_DATA,  32'h200, 1'b0, 32'h0, STRB_HALF);
    run_until(2, 2, en);
    chk("t2_access_cycles", 160'(en), 160'(4));
    repeat (2) @(negedge clk);

    // Write with four wait states; m1_rdata must keep the previous read value
    s_wait = 4; apb_rdata = 32'hBAD0_BAD0;
    expect_txn(M_DATA, 32'h20, 1'b1, 32'h1234_5678, STRB_HALF, 1'b0, 32'hA5A5_0001);
    issue(M_DATA, 32'h20, 1'b1, 32'h1234_5678, STRB_HALF);
    run_until(0, 1, en);
    chk("t3_access_cycles", 160'(en), 160'(5));
    repeat (2) @(negedge clk);

    // Watchdog: 16 ACCESS cycles then an error completion, then a clean transfer
    s_never = 1'b1;
    expect_txn(M_FETCH, 32'h30, 1'b0, 32'h0, STRB_BYTE, 1'b1, 32'h0);
    issue(M_FETCH, 32'h30, 1'b0, 32'h0, STRB_BYTE);
    run_until(1, 0, en);
    chk("t4_access_cycles", 160'(en), 160'(16));
    chk("t4_done_bus", 160'({apb_sel, apb_en, m0_done, m0_err}), 160'(4'b0011));
    s_never = 1'b0; s_wait = 1; apb_rdata = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    expect_txn(M_FETCH, 32'h40, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h0BAD_F00D);
    issue(M_FETCH, 32'h40, 1'b0, 32'h0, STRB_WORD);
    run_until(1, 0, en);
    chk("t4b_access_cycles", 160'(en), 160'(2));
    repeat (2) @(negedge clk);

    // m0 held through done with m1 pending: m1 goes next, then m0 again
    s_wait = 0; apb_rdata = 32'h1111_2222;
    expect_txn(M_FETCH, 32'h50, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h1111_2222);
    expect_txn(M_DATA,  32'h60, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h1111_2222);
    expect_txn(M_FETCH, 32'h50, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h1111_2222);
    issue(M_FETCH, 32'h50, 1'b0, 32'h0, STRB_WORD);
    @(negedge clk);
    issue(M_DATA, 32'h60, 1'b0, 32'h0, STRB_WORD);
    run_until(2, 1, en);
    repeat (2) @(negedge clk);

    // m0 held alone: cooldown cycle, then re-granted
    apb_rdata = 32'h3333_4444;
    expect_txn(M_FETCH, 32'h54, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h3333_4444);
    expect_txn(M_FETCH, 32'h54, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h3333_4444);
    issue(M_FETCH, 32'h54, 1'b0, 32'h0, STRB_WORD);
    k = 0;
    while (k < 50 && m0_done !== 1'b1) begin @(negedge clk); k++; end
    chk("t6_first_done", 160'(m0_done), 160'(1));
    @(negedge clk);
    chk("t6_cooldown", 160'({m0_gnt, apb_sel}), 160'(2'b00));
    @(negedge clk);
    chk("t6_regrant", 160'({m0_gnt, apb_sel}), 160'(2'b11));
    run_until(1, 0, en);
    repeat (2) @(negedge clk);

    // Reset in the middle of an m1 read: everything clears, no done follows
    s_never = 1'b1;
    expect_txn(M_DATA, 32'h70, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h0);
    issue(M_DATA, 32'h70, 1'b0, 32'h0, STRB_WORD);
    k = 0;
    while (k < 50 && apb_en !== 1'b1) begin @(negedge clk); k++; end
    chk("t5_in_access", 160'(apb_en), 160'(1));
    rts = 1'b1;
    @(negedge clk);
    chk("t5_rst_ctrl", 160'({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, apb_sel, apb_en, apb_wr}), 160'(0));
    chk("t5_rst_data", 160'({m0_rdata, m1_rdata, apb_addr, apb_wdata, apb_strb}), 160'(0));
    q.delete();
    m1_req = 1'b0; rts = 1'b0; s_never = 1'b0; s_wait = 0;
    repeat (4) @(negedge clk);
    chk("t5_no_done", 160'({m1_done, m0_done}), 160'(0));
    apb_rdata = 32'h5555_6666;
    expect_txn(M_FETCH, 32'h80, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h5555_6666);
    expect_txn(M_DATA,  32'h90, 1'b0, 32'h0, STRB_WORD, 1'b0, 32'h5555_6666);
    issue(M_FETCH, 32'h80, 1'b0, 32'h0, STRB_WORD);
    issue(M_DATA,  32'h90, 1'b0, 32'h0, STRB_WORD);
    run_until(1, 1, en);
    repeat (3) @(negedge clk);
    chk("queue_drained", 160'(q.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
